// File: rtl/ahfp_mult_seq.sv
// Multi-cycle floating-point multiplier (round-to-nearest-even, flush-to-zero)
// for a clk_en/start/done custom-instruction port.
module ahfp_mult_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int BIAS  = (1 << (EXP_W - 1)) - 1,
   localparam int W    = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clk_en,
   input  logic         start,
   input  logic [W-1:0] dataa,
   input  logic [W-1:0] datab,
   output logic [W-1:0] result,
   output logic         done
);

   localparam int PW = 2 * (MAN_W + 1);
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_NORM, S_ROUND} state_t;
   typedef enum logic [1:0] {C_NUM, C_NAN, C_INF, C_ZERO} cls_t;

   state_t                r_state;
   cls_t                  r_cls;
   logic [W-1:0]          r_a, r_b, r_result;
   logic                  r_sign, r_done, r_g, r_s;
   logic [PW-1:0]         r_prod;
   logic signed [EW-1:0]  r_exp;
   logic [MAN_W-1:0]      r_frac;

   logic [EXP_W-1:0]      w_ea, w_eb;
   logic [MAN_W-1:0]      w_fa, w_fb;
   logic                  w_a_max, w_b_max, w_a_zero, w_b_zero;
   cls_t                  w_cls;
   logic [PW-1:0]         w_prod;
   logic signed [EW-1:0]  w_esum;
   logic [PW-2:0]         w_norm;
   logic                  w_inc, w_carry;
   logic [MAN_W-1:0]      w_rfrac;
   logic signed [EW-1:0]  w_fexp;
   logic [W-1:0]          w_res;

   assign w_ea     = r_a[W-2 -: EXP_W];
   assign w_eb     = r_b[W-2 -: EXP_W];
   assign w_fa     = r_a[MAN_W-1:0];
   assign w_fb     = r_b[MAN_W-1:0];
   assign w_a_max  = &w_ea;
   assign w_b_max  = &w_eb;
   assign w_a_zero = (w_ea == '0);
   assign w_b_zero = (w_eb == '0);

   always_comb begin
      w_cls = C_NUM;
      if ((w_a_max && |w_fa) || (w_b_max && |w_fb) ||
          (w_a_max && w_b_zero) || (w_b_max && w_a_zero))
         w_cls = C_NAN;
      else if (w_a_max || w_b_max)
         w_cls = C_INF;
      else if (w_a_zero || w_b_zero)
         w_cls = C_ZERO;
   end

   assign w_prod = PW'({1'b1, w_fa}) * PW'({1'b1, w_fb});
   assign w_esum = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);

   // Leading one is dropped: after this select it always sits just above w_norm.
   assign w_norm = r_prod[PW-1] ? r_prod[PW-2:0] : {r_prod[PW-3:0], 1'b0};

   assign w_inc              = r_g & (r_s | r_frac[0]);
   assign {w_carry, w_rfrac} = {1'b0, r_frac} + (MAN_W + 1)'(w_inc);
   assign w_fexp             = r_exp + EW'(w_carry);

   always_comb begin
      w_res = {r_sign, w_fexp[EXP_W-1:0], w_rfrac};
      case (r_cls)
         C_NAN:   w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         C_INF:   w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         C_ZERO:  w_res = {r_sign, {(W-1){1'b0}}};
         default: begin
            if (w_fexp >= EXP_MAX)
               w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else if (w_fexp <= EXP_ZERO)
               w_res = {r_sign, {(W-1){1'b0}}};
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cls    <= C_NUM;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_sign   <= 1'b0;
         r_done   <= 1'b0;
         r_g      <= 1'b0;
         r_s      <= 1'b0;
         r_prod   <= '0;
         r_exp    <= '0;
         r_frac   <= '0;
      end else if (clk_en) begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= dataa;
                  r_b     <= datab;
                  r_state <= S_MULT;
               end
            end
            S_MULT: begin
               r_sign  <= r_a[W-1] ^ r_b[W-1];
               r_cls   <= w_cls;
               r_prod  <= w_prod;
               r_exp   <= w_esum;
               r_state <= S_NORM;
            end
            S_NORM: begin
               r_frac  <= w_norm[PW-2 -: MAN_W];
               r_g     <= w_norm[PW-2-MAN_W];
               r_s     <= |w_norm[PW-3-MAN_W:0];
               r_exp   <= r_exp + EW'(r_prod[PW-1]);
               r_state <= S_ROUND;
            end
            default: begin
               r_result <= w_res;
               r_done   <= 1'b1;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign result = r_result;
   assign done   = r_done;

endmodule
